// File: rtl/id_imm_ctrl_if.sv
// Decode-to-EX bus for id_imm_ctrl: IF/ID handshake, immediate-generator
// select/result, and the registered ID/EX immediate-bearing fields.
interface id_imm_ctrl_if;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [2:0]  ImmSel;
  logic [31:0] imm_in;
  logic        ex_ready;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic        ex_is_load;
  logic        ex_illegal;
  logic [15:0] bubble_cnt;

  modport master (
    output if_valid, if_inst, if_pc, imm_in, ex_ready, flush,
    input  id_ready, ImmSel, ex_valid, ex_pc, ex_imm, ex_rd, ex_rs1, ex_rs2,
           ex_is_load, ex_illegal, bubble_cnt
  );

  modport slave (
    input  if_valid, if_inst, if_pc, imm_in, ex_ready, flush,
    output id_ready, ImmSel, ex_valid, ex_pc, ex_imm, ex_rd, ex_rs1, ex_rs2,
           ex_is_load, ex_illegal, bubble_cnt
  );
endinterface

// File: rtl/id_imm_ctrl.sv
// Decode-stage immediate controller and ID/EX register with load-use bubbles and flush.
// Optional macro ID_AUIPC_EN makes opcode 0010111 (AUIPC) a legal U-type instruction.
module id_imm_ctrl (
  input  logic          clk,
  input  logic          rst,
  id_imm_ctrl_if.slave  bus
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] SEL_U    = 3'b000;
  localparam logic [2:0] SEL_I    = 3'b001;
  localparam logic [2:0] SEL_S    = 3'b010;
  localparam logic [2:0] SEL_B    = 3'b011;
  localparam logic [2:0] SEL_J    = 3'b100;
  localparam logic [2:0] SEL_NONE = 3'b111;

  logic [6:0]  opcode;
  logic [2:0]  imm_sel;
  logic        use_rd;
  logic        use_rs1;
  logic        use_rs2;
  logic        dec_load;
  logic        dec_illegal;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [31:0] dec_imm;

  logic        ex_valid_q,   ex_valid_d;
  logic [31:0] ex_pc_q,      ex_pc_d;
  logic [31:0] ex_imm_q,     ex_imm_d;
  logic [4:0]  ex_rd_q,      ex_rd_d;
  logic [4:0]  ex_rs1_q,     ex_rs1_d;
  logic [4:0]  ex_rs2_q,     ex_rs2_d;
  logic        ex_is_load_q, ex_is_load_d;
  logic        ex_illegal_q, ex_illegal_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  logic slot_free;
  logic hazard;
  logic id_ready;
  logic transfer;

  // Funct fields and the upper immediate bits are handled by the immediate generator.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{bus.if_inst[31:25], bus.if_inst[14:12]};

  assign opcode = bus.if_inst[6:0];

  always_comb begin
    imm_sel     = SEL_NONE;
    use_rd      = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    dec_load    = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OP_LUI: begin
        imm_sel = SEL_U;
        use_rd  = 1'b1;
      end
`ifdef ID_AUIPC_EN
      OP_AUIPC: begin
        imm_sel = SEL_U;
        use_rd  = 1'b1;
      end
`endif
      OP_LOAD: begin
        imm_sel  = SEL_I;
        use_rd   = 1'b1;
        use_rs1  = 1'b1;
        dec_load = 1'b1;
      end
      OP_IMM, OP_JALR: begin
        imm_sel = SEL_I;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_STORE: begin
        imm_sel = SEL_S;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        imm_sel = SEL_B;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_JAL: begin
        imm_sel = SEL_J;
        use_rd  = 1'b1;
      end
      OP_REG: begin
        imm_sel = SEL_NONE;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: begin
        imm_sel     = SEL_NONE;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Unused register fields are zeroed here so the hazard compare never matches stale bits.
  assign dec_rd  = use_rd  ? bus.if_inst[11:7]  : 5'd0;
  assign dec_rs1 = use_rs1 ? bus.if_inst[19:15] : 5'd0;
  assign dec_rs2 = use_rs2 ? bus.if_inst[24:20] : 5'd0;
  assign dec_imm = (imm_sel != SEL_NONE) ? bus.imm_in : 32'd0;

  assign slot_free = !ex_valid_q || bus.ex_ready;
  assign hazard    = ex_valid_q && ex_is_load_q && (ex_rd_q != 5'd0) && bus.if_valid &&
                     ((ex_rd_q == dec_rs1) || (ex_rd_q == dec_rs2));
  assign id_ready  = slot_free && !hazard && !bus.flush;
  assign transfer  = bus.if_valid && id_ready;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_imm_d     = ex_imm_q;
    ex_rd_d      = ex_rd_q;
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    ex_is_load_d = ex_is_load_q;
    ex_illegal_d = ex_illegal_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.flush) begin
      ex_valid_d = 1'b0;
    end else if (slot_free && hazard) begin
      ex_valid_d = 1'b0;
      if (bubble_cnt_q != 16'hFFFF) begin
        bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
    end else if (transfer) begin
      ex_valid_d   = 1'b1;
      ex_pc_d      = bus.if_pc;
      ex_imm_d     = dec_imm;
      ex_rd_d      = dec_rd;
      ex_rs1_d     = dec_rs1;
      ex_rs2_d     = dec_rs2;
      ex_is_load_d = dec_load;
      ex_illegal_d = dec_illegal;
    end else if (slot_free) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= 32'd0;
      ex_imm_q     <= 32'd0;
      ex_rd_q      <= 5'd0;
      ex_rs1_q     <= 5'd0;
      ex_rs2_q     <= 5'd0;
      ex_is_load_q <= 1'b0;
      ex_illegal_q <= 1'b0;
      bubble_cnt_q <= 16'd0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_imm_q     <= ex_imm_d;
      ex_rd_q      <= ex_rd_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_is_load_q <= ex_is_load_d;
      ex_illegal_q <= ex_illegal_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.id_ready   = id_ready;
  assign bus.ImmSel     = imm_sel;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_pc      = ex_pc_q;
  assign bus.ex_imm     = ex_imm_q;
  assign bus.ex_rd      = ex_rd_q;
  assign bus.ex_rs1     = ex_rs1_q;
  assign bus.ex_rs2     = ex_rs2_q;
  assign bus.ex_is_load = ex_is_load_q;
  assign bus.ex_illegal = ex_illegal_q;
  assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_imm_ctrl.sv
// Directed-vector bench for id_imm_ctrl: decode table, load-use bubbles, backpressure,
// flush priority, reset mid-stall, optional AUIPC (ID_AUIPC_EN) and counter saturation.
module tb_id_imm_ctrl;

  localparam logic [31:0] I_LUI0  = 32'h12345037;
  localparam logic [31:0] I_LW5   = 32'h0040A283;
  localparam logic [31:0] I_ADD6  = 32'h00228333;
  localparam logic [31:0] I_ADDI9 = 32'hFFF50493;
  localparam logic [31:0] I_SW    = 32'h00322423;
  localparam logic [31:0] I_BEQ   = 32'h00208063;
  localparam logic [31:0] I_JAL1  = 32'h000000EF;
  localparam logic [31:0] I_JALR1 = 32'h000100E7;
  localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;
  localparam logic [31:0] I_AUIPC = 32'h00001397;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;

  id_imm_ctrl_if bus ();

  id_imm_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] imm);
    bus.if_valid = 1'b1;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
    bus.imm_in   = imm;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    present(I_LW5, 32'h40, 32'h4);
    bus.ex_ready = 1'b1;
    step();
    step();
    vec_cnt++;
    if ({bus.ex_valid, bus.ex_is_load, bus.ex_illegal, bus.ex_rd, bus.ex_rs1, bus.ex_rs2} !== 18'd0) begin
      err_cnt++;
      $display("[TB] FAIL reset_flags: got %h expected 0",
               {bus.ex_valid, bus.ex_is_load, bus.ex_illegal, bus.ex_rd, bus.ex_rs1, bus.ex_rs2});
    end
    vec_cnt++;
    if ({bus.ex_pc, bus.ex_imm, bus.bubble_cnt} !== 80'd0) begin
      err_cnt++;
      $display("[TB] FAIL reset_data: pc %h imm %h cnt %h expected all 0", bus.ex_pc, bus.ex_imm, bus.bubble_cnt);
    end
    rst = 1'b0;
    bus.if_valid = 1'b0;
  endtask

  task automatic test_lui();
    present(I_LUI0, 32'h1000, 32'h12345000);
    #1;
    vec_cnt++;
    if ({bus.ImmSel, bus.id_ready} !== {3'b000, 1'b1}) begin
      err_cnt++;
      $display("[TB] FAIL lui_comb: ImmSel %b id_ready %b expected 000 1", bus.ImmSel, bus.id_ready);
    end
    step();
    bus.if_valid = 1'b0;
    vec_cnt++;
    if ({bus.ex_valid, bus.ex_is_load, bus.ex_illegal, bus.ex_rd, bus.ex_rs1, bus.ex_rs2} !== {3'b100, 15'd0}) begin
      err_cnt++;
      $display("[TB] FAIL lui_flags: got %h expected %h",
               {bus.ex_valid, bus.ex_is_load, bus.ex_illegal, bus.ex_rd, bus.ex_rs1, bus.ex_rs2}, {3'b100, 15'd0});
    end
    vec_cnt++;
    if ({bus.ex_imm, bus.ex_pc} !== {32'h12345000, 32'h1000}) begin
      err_cnt++;
      $display("[TB] FAIL lui_data: imm %h pc %h expected 12345000 00001000", bus.ex_imm, bus.ex_pc);
    end
    step();
    vec_cnt++;
    if (bus.ex_valid !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL lui_drain: ex_valid %b expected 0", bus.ex_valid);
    end
  endtask

  // Back-to-back decode table: one instruction per cycle, checks ImmSel then the registered fields.
  task automatic test_decode_back_to_back();
    logic [31:0] inst [7];
    logic [31:0] imm  [7];
    logic [2:0]  sel  [7];
    logic [15:0] flds [7];
    logic        ill  [7];
    inst[0] = I_SW;    imm[0] = 32'h8;        sel[0] = 3'b010; flds[0] = {1'b0, 5'd0, 5'd4,  5'd3}; ill[0] = 1'b0;
    inst[1] = I_BEQ;   imm[1] = 32'h10;       sel[1] = 3'b011; flds[1] = {1'b0, 5'd0, 5'd1,  5'd2}; ill[1] = 1'b0;
    inst[2] = I_JAL1;  imm[2] = 32'h800;      sel[2] = 3'b100; flds[2] = {1'b0, 5'd1, 5'd0,  5'd0}; ill[2] = 1'b0;
    inst[3] = I_ADDI9; imm[3] = 32'hFFFFFFFF; sel[3] = 3'b001; flds[3] = {1'b0, 5'd9, 5'd10, 5'd0}; ill[3] = 1'b0;
    inst[4] = I_JALR1; imm[4] = 32'h0;        sel[4] = 3'b001; flds[4] = {1'b0, 5'd1, 5'd2,  5'd0}; ill[4] = 1'b0;
    inst[5] = I_BAD;   imm[5] = 32'hCAFE0000; sel[5] = 3'b111; flds[5] = {1'b0, 5'd0, 5'd0,  5'd0}; ill[5] = 1'b1;
    inst[6] = I_ADD6;  imm[6] = 32'hDEADBEEF; sel[6] = 3'b111; flds[6] = {1'b0, 5'd6, 5'd5,  5'd2}; ill[6] = 1'b0;
    bus.ex_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      present(inst[i], 32'h2000 + 32'(i * 4), imm[i]);
      #1;
      vec_cnt++;
      if ({bus.ImmSel, bus.id_ready} !== {sel[i], 1'b1}) begin
        err_cnt++;
        $display("[TB] FAIL decode_sel[%0d]: ImmSel %b id_ready %b expected %b 1", i, bus.ImmSel, bus.id_ready, sel[i]);
      end
      step();
      vec_cnt++;
      if ({bus.ex_valid, bus.ex_illegal, bus.ex_rd, bus.ex_rs1, bus.ex_rs2, bus.ex_pc, bus.ex_imm} !==
          {1'b1, ill[i], flds[i][14:0], 32'h2000 + 32'(i * 4), (sel[i] == 3'b111) ? 32'd0 : imm[i]}) begin
        err_cnt++;
        $display("[TB] FAIL decode_regs[%0d]: v %b ill %b rd %0d rs1 %0d rs2 %0d pc %h imm %h expected ill %b fields %h pc %h",
                 i, bus.ex_valid, bus.ex_illegal, bus.ex_rd, bus.ex_rs1, bus.ex_rs2, bus.ex_pc, bus.ex_imm,
                 ill[i], flds[i][14:0], 32'h2000 + 32'(i * 4));
      end
    end
    bus.if_valid = 1'b0;
    step();
  endtask

  task automatic test_load_use();
    bus.ex_ready = 1'b1;
    present(I_LW5, 32'h3000, 32'h4);
    step();
    vec_cnt++;
    if ({bus.ex_valid, bus.ex_is_load, bus.ex_rd, bus.ex_rs1, bus.ex_rs2, bus.ex_imm} !== {2'b11, 5'd5, 5'd1, 5'd0, 32'h4}) begin
      err_cnt++;
      $display("[TB] FAIL lw_capture: v %b ld %b rd %0d rs1 %0d rs2 %0d imm %h expected 1 1 5 1 0 4",
               bus.ex_valid, bus.ex_is_load, bus.ex_rd, bus.ex_rs1, bus.ex_rs2, bus.ex_imm);
    end
    present(I_ADD6, 32'h3004, 32'h0);
    #1;
    vec_cnt++;
    if (bus.id_ready !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL load_use_stall: id_ready %b expected 0", bus.id_ready);
    end
    step();
    vec_cnt++;
    if ({bus.ex_valid, bus.bubble_cnt, bus.id_ready} !== {1'b0, 16'd1, 1'b1}) begin
      err_cnt++;
      $display("[TB] FAIL load_use_bubble: ex_valid %b cnt %0d id_ready %b expected 0 1 1",
               bus.ex_valid, bus.bubble_cnt, bus.id_ready);
    end
    step();
    vec_cnt++;
    if ({bus.ex_valid, bus.ex_is_load, bus.ex_rd, bus.ex_rs1, bus.ex_rs2, bus.ex_pc} !== {2'b10, 5'd6, 5'd5, 5'd2, 32'h3004}) begin
      err_cnt++;
      $display("[TB] FAIL load_use_add: v %b ld %b rd %0d rs1 %0d rs2 %0d pc %h expected 1 0 6 5 2 3004",
               bus.ex_valid, bus.ex_is_load, bus.ex_rd, bus.ex_rs1, bus.ex_rs2, bus.ex_pc);
    end
    // Independent follower after a load must not stall.
    present(I_LW5, 32'h3008, 32'h4);
    step();
    present(I_ADDI9, 32'h300C, 32'hFFFFFFFF);
    #1;
    vec_cnt++;
    if (bus.id_ready !== 1'b1) begin
      err_cnt++;
      $display("[TB] FAIL load_no_dep: id_ready %b expected 1", bus.id_ready);
    end
    step();
    bus.if_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    bus.ex_ready = 1'b1;
    present(I_JAL1, 32'h100, 32'h800);
    step();
    present(I_SW, 32'h104, 32'h8);
    bus.ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec_cnt++;
      if (bus.id_ready !== 1'b0) begin
        err_cnt++;
        $display("[TB] FAIL bp_ready[%0d]: id_ready %b expected 0", i, bus.id_ready);
      end
      step();
      vec_cnt++;
      if ({bus.ex_valid, bus.ex_rd, bus.ex_pc, bus.ex_imm} !== {1'b1, 5'd1, 32'h100, 32'h800}) begin
        err_cnt++;
        $display("[TB] FAIL bp_hold[%0d]: v %b rd %0d pc %h imm %h expected 1 1 100 800",
                 i, bus.ex_valid, bus.ex_rd, bus.ex_pc, bus.ex_imm);
      end
    end
    bus.ex_ready = 1'b1;
    #1;
    vec_cnt++;
    if (bus.id_ready !== 1'b1) begin
      err_cnt++;
      $display("[TB] FAIL bp_release: id_ready %b expected 1", bus.id_ready);
    end
    step();
    bus.if_valid = 1'b0;
    vec_cnt++;
    if ({bus.ex_valid, bus.ex_rd, bus.ex_rs1, bus.ex_rs2, bus.ex_pc, bus.ex_imm} !== {1'b1, 5'd0, 5'd4, 5'd3, 32'h104, 32'h8}) begin
      err_cnt++;
      $display("[TB] FAIL bp_transfer: v %b rd %0d rs1 %0d rs2 %0d pc %h imm %h expected 1 0 4 3 104 8",
               bus.ex_valid, bus.ex_rd, bus.ex_rs1, bus.ex_rs2, bus.ex_pc, bus.ex_imm);
    end
    step();
  endtask

  task automatic test_flush();
    bus.ex_ready = 1'b1;
    present(I_JAL1, 32'h200, 32'h800);
    step();
    present(I_BEQ, 32'h204, 32'h10);
    bus.flush = 1'b1;
    #1;
    vec_cnt++;
    if (bus.id_ready !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL flush_ready: id_ready %b expected 0", bus.id_ready);
    end
    step();
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
    vec_cnt++;
    if ({bus.ex_valid, bus.ex_pc} !== {1'b0, 32'h200}) begin
      err_cnt++;
      $display("[TB] FAIL flush_kill: ex_valid %b pc %h expected 0 200", bus.ex_valid, bus.ex_pc);
    end
    // Flush while EX is back-pressured still empties ID/EX.
    present(I_JAL1, 32'h300, 32'h800);
    step();
    bus.ex_ready = 1'b0;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.ex_ready = 1'b1;
    bus.if_valid = 1'b0;
    vec_cnt++;
    if (bus.ex_valid !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL flush_stalled: ex_valid %b expected 0", bus.ex_valid);
    end
    // Flush coinciding with a load-use hazard: no bubble counted.
    present(I_LW5, 32'h400, 32'h4);
    step();
    present(I_ADD6, 32'h404, 32'h0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
    vec_cnt++;
    if ({bus.ex_valid, bus.bubble_cnt} !== {1'b0, 16'd1}) begin
      err_cnt++;
      $display("[TB] FAIL flush_hazard: ex_valid %b cnt %0d expected 0 1", bus.ex_valid, bus.bubble_cnt);
    end
    step();
  endtask

  task automatic test_hazard_stall_reset();
    bus.ex_ready = 1'b1;
    present(I_LW5, 32'h500, 32'h4);
    step();
    present(I_ADD6, 32'h504, 32'h0);
    bus.ex_ready = 1'b0;
    step();
    vec_cnt++;
    if ({bus.ex_valid, bus.ex_rd, bus.ex_pc, bus.bubble_cnt} !== {1'b1, 5'd5, 32'h500, 16'd1}) begin
      err_cnt++;
      $display("[TB] FAIL hazard_stall: v %b rd %0d pc %h cnt %0d expected 1 5 500 1",
               bus.ex_valid, bus.ex_rd, bus.ex_pc, bus.bubble_cnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.if_valid = 1'b0;
    bus.ex_ready = 1'b1;
    vec_cnt++;
    if ({bus.ex_valid, bus.ex_is_load, bus.ex_rd, bus.ex_pc, bus.bubble_cnt} !== 55'd0) begin
      err_cnt++;
      $display("[TB] FAIL reset_in_stall: v %b ld %b rd %0d pc %h cnt %0d expected all 0",
               bus.ex_valid, bus.ex_is_load, bus.ex_rd, bus.ex_pc, bus.bubble_cnt);
    end
  endtask

  task automatic test_auipc();
    logic [2:0] exp_sel;
    logic       exp_ill;
    logic [4:0] exp_rd;
    logic [31:0] exp_imm;
`ifdef ID_AUIPC_EN
    exp_sel = 3'b000; exp_ill = 1'b0; exp_rd = 5'd7; exp_imm = 32'h1000;
`else
    exp_sel = 3'b111; exp_ill = 1'b1; exp_rd = 5'd0; exp_imm = 32'h0;
`endif
    bus.ex_ready = 1'b1;
    present(I_AUIPC, 32'h600, 32'h1000);
    #1;
    vec_cnt++;
    if (bus.ImmSel !== exp_sel) begin
      err_cnt++;
      $display("[TB] FAIL auipc_sel: ImmSel %b expected %b", bus.ImmSel, exp_sel);
    end
    step();
    bus.if_valid = 1'b0;
    vec_cnt++;
    if ({bus.ex_valid, bus.ex_illegal, bus.ex_rd, bus.ex_rs1, bus.ex_imm} !== {1'b1, exp_ill, exp_rd, 5'd0, exp_imm}) begin
      err_cnt++;
      $display("[TB] FAIL auipc_regs: v %b ill %b rd %0d rs1 %0d imm %h expected 1 %b %0d 0 %h",
               bus.ex_valid, bus.ex_illegal, bus.ex_rd, bus.ex_rs1, bus.ex_imm, exp_ill, exp_rd, exp_imm);
    end
    step();
  endtask

  // Counter preloaded near the top so saturation is reached in a handful of hazards.
  task automatic test_saturation();
    bus.ex_ready = 1'b1;
    bus.if_valid = 1'b0;
    force dut.bubble_cnt_q = 16'hFFFC;
    step();
    release dut.bubble_cnt_q;
    for (int i = 0; i < 6; i++) begin
      present(I_LW5, 32'h700, 32'h4);
      step();
      present(I_ADD6, 32'h704, 32'h0);
      step();
      if (i == 1) begin
        vec_cnt++;
        if (bus.bubble_cnt !== 16'hFFFE) begin
          err_cnt++;
          $display("[TB] FAIL sat_climb: cnt %h expected fffe", bus.bubble_cnt);
        end
      end
    end
    bus.if_valid = 1'b0;
    vec_cnt++;
    if (bus.bubble_cnt !== 16'hFFFF) begin
      err_cnt++;
      $display("[TB] FAIL sat_hold: cnt %h expected ffff", bus.bubble_cnt);
    end
  endtask

  initial begin
    vec_cnt      = 0;
    err_cnt      = 0;
    rst          = 1'b1;
    bus.if_valid = 1'b0;
    bus.if_inst  = 32'd0;
    bus.if_pc    = 32'd0;
    bus.imm_in   = 32'd0;
    bus.ex_ready = 1'b0;
    bus.flush    = 1'b0;
    test_reset();
    test_lui();
    test_decode_back_to_back();
    test_load_use();
    test_backpressure();
    test_flush();
    test_hazard_stall_reset();
    test_auipc();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
